spi_alu_bridge: RTL and testbench
=================================

# spi_alu_bridge

SPI slave front end that turns a serial command frame into one ALU operation request and shifts the ALU's result back out on MISO in the same frame. It is the upstream counterpart of the SPI project's `alu` block. It drives the ALU's `valid_i`/`data_i_1`/`data_i_2`/`sel_i` inputs and consumes its `valid_o`/`data_o` outputs. It oversamples SPI mode 0 in the single system clock domain, and sits between the chip pins and the ALU.

## Interface
- `DATA_WIDTH`, 8: operand width; result width is `2*DATA_WIDTH`.
- `SEL_WIDTH`, 2: ALU select width; must be ≤ 8.
- `SYNC_STAGES`, 2: synchronizer depth for `spi_sclk_i`, `spi_cs_n_i` and `spi_mosi_i`.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_sclk_i` in 1: SPI clock, asynchronous.
- `spi_cs_n_i` in 1: chip select, active low, asynchronous.
- `spi_mosi_i` in 1: serial data in, MSB first.
- `spi_miso_o` out 1: serial data out, MSB first.
- `alu_valid_o` out 1: one-cycle operation request to the ALU.
- `alu_data_1_o` out DATA_WIDTH: operand 1.
- `alu_data_2_o` out DATA_WIDTH: operand 2.
- `alu_sel_o` out SEL_WIDTH: operation select.
- `alu_valid_i` in 1: result valid from the ALU.
- `alu_data_i` in 2*DATA_WIDTH: ALU result.
- `busy_o` out 1: high whenever the FSM is not in IDLE.
- `err_o` out 1: sticky result-missed flag; cleared at the next frame start.

## Operation
Frame layout, while CS is low. Let N = 2*DATA_WIDTH.
- Byte 0: select byte. Its low SEL_WIDTH bits are `sel`; the upper bits are ignored.
- Next DATA_WIDTH bits: operand 1.
- Next DATA_WIDTH bits: operand 2.
- 8 turnaround bits: MOSI ignored, MISO = 0.
- Next N bits: result on MISO.
- Any further bits: MOSI ignored, MISO = 0.

SPI mode 0:
- MOSI is sampled on detected SCLK rising edges.
- MISO changes on detected SCLK falling edges.
- MISO = 0 when CS is high.

FSM states:
- IDLE: wait for detected CS fall. On CS fall, clear the bit counter and `err_o`, then go to RX_CMD.
- RX_CMD: shift MOSI into the command shift register. After the last operand-2 bit is sampled, go to ISSUE.
- ISSUE: for exactly one clk, drive `alu_valid_o` = 1 with the latched operands and select. Go to WAIT.
- WAIT: on `alu_valid_i`, load `alu_data_i` into the TX shift register. Otherwise keep counting turnaround bits.
  - If the falling edge after the last turnaround bit arrives and no result has been loaded, set `err_o`, load 0, and go to TX.
  - If the result was loaded in time, go to TX on that same falling edge, driving the result MSB.
- TX: shift out one bit per falling edge. After N bits, go to DONE.
- DONE: hold MISO = 0 until CS rises.

Global rules:
- CS rise in any state returns the FSM to IDLE. The partial frame is discarded.
- A CS rise after ISSUE leaves the already-issued request in place, but any late `alu_valid_i` is ignored.
- `alu_valid_i` outside WAIT is ignored.
- `sel` = 3 is forwarded unchanged; the ALU returns 0 for it.
- Operand and select outputs hold their last values between requests.

Reset values:
- All outputs are 0.
- FSM is in IDLE and all counters are 0.
- Reset mid-frame aborts with no `alu_valid_o`. The bridge resynchronizes at the next CS fall, not mid-frame.

## Timing
- Pin-to-event latency is SYNC_STAGES + 1 clk, for edge detection on the synchronized signals.
- Required SCLK timing: high ≥ 4 clk, low ≥ 4 clk.
- Required CS timing: CS high ≥ 4 clk between frames; first SCLK edge ≥ 4 clk after CS falls.
- `alu_valid_o` rises 1 clk after the clk in which the last operand bit is shifted in. It is high for exactly 1 clk.
- The ALU returns its result 2 clk after the request; the turnaround byte covers this with margin.
- MISO updates 1 clk after the detected falling edge.
- Simultaneous detected CS rise and SCLK edge: CS wins, and the bit is discarded.

## Structure
- Shared package `spi_alu_pkg` holds:
  - the FSM state enum;
  - `TURN_BITS` = 8 and `SEL_BYTE_BITS` = 8;
  - the frame-length function of DATA_WIDTH.
- Sub-module `spi_sync_edge` does the SYNC_STAGES synchronizer plus rise/fall detection. It is instantiated for SCLK and CS; MOSI uses the synchronizer only.
- Top level `spi_alu_bridge` contains the FSM, bit counter and the two shift registers.

## Test plan
- Add: `sel` = 0x00, operands 0x12, 0x34, with the real `alu` attached → `alu_valid_o` pulses once; MISO returns 0x0046; `err_o` = 0.
- Subtract: `sel` = 0x01, operands 0x10, 0x20 → MISO returns 0xFFF0.
- Increment: `sel` = 0x02, operand 1 = 0xFF → MISO returns 0x0100. Then, in a back-to-back frame with 4 clk of CS high, `sel` = 0x03 → MISO returns 0x0000.
- Abort: CS rises after bit 10 → no `alu_valid_o`; `busy_o` falls within SYNC_STAGES + 2 clk; the next frame works normally.
- Late ALU: a mock ALU never asserts `alu_valid_i` → `err_o` = 1, MISO returns 0x0000, and `err_o` clears at the next CS fall.
- Reset: `rst_n` pulses low mid-TX → all outputs read 0 immediately; after CS cycles high then low, a fresh add of 0x01 + 0x01 returns 0x0002.

Source files
------------

// File: rtl/spi_alu_bridge_pkg.sv
// Shared types and frame geometry for the SPI-to-ALU bridge.
package spi_alu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRxCmd,
        StIssue,
        StWait,
        StTx,
        StDone
    } state_e;

    localparam int unsigned TURN_BITS     = 8;
    localparam int unsigned SEL_BYTE_BITS = 8;

    // Select byte, two operands, turnaround, then a double-width result.
    function automatic int unsigned frame_bits(input int unsigned data_width);
        return SEL_BYTE_BITS + 2 * data_width + TURN_BITS + 2 * data_width;
    endfunction

endpackage

// File: rtl/spi_alu_bridge_if.sv
// Request/result handshake between the bridge (master) and the ALU (slave).
interface spi_alu_bridge_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEL_WIDTH  = 2
) ();

    logic                    alu_valid_o;
    logic [DATA_WIDTH-1:0]   alu_data_1_o;
    logic [DATA_WIDTH-1:0]   alu_data_2_o;
    logic [SEL_WIDTH-1:0]    alu_sel_o;
    logic                    alu_valid_i;
    logic [2*DATA_WIDTH-1:0] alu_data_i;

    modport master (
        output alu_valid_o, alu_data_1_o, alu_data_2_o, alu_sel_o,
        input  alu_valid_i, alu_data_i
    );

    modport slave (
        input  alu_valid_o, alu_data_1_o, alu_data_2_o, alu_sel_o,
        output alu_valid_i, alu_data_i
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with rise/fall pulse detection.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Resetting to 0 means a CS held low through reset never looks like a fresh fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_alu_bridge.sv
// SPI mode-0 slave that turns one command frame into one ALU request and
// shifts the ALU result back out on MISO within the same frame.
module spi_alu_bridge
    import spi_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SEL_WIDTH   = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              busy_o,
    output logic              err_o,
    spi_alu_bridge_if.master  alu
);

    localparam int unsigned N          = 2 * DATA_WIDTH;
    localparam int unsigned RX_BITS    = SEL_BYTE_BITS + 2 * DATA_WIDTH;
    localparam int unsigned TX_START   = RX_BITS + TURN_BITS;
    localparam int unsigned FRAME_BITS = frame_bits(DATA_WIDTH);
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
    // Only the low select bits survive; the ignored upper bits shift out the top.
    localparam int unsigned RX_W       = SEL_WIDTH + 2 * DATA_WIDTH;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    state_e                state_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [RX_W-1:0]       rx_shift_q;
    logic [N-1:0]          tx_shift_q;
    logic                  miso_q, err_q, loaded_q, alu_valid_q;
    logic [DATA_WIDTH-1:0] data_1_q, data_2_q;
    logic [SEL_WIDTH-1:0]  sel_q;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (spi_sclk_i),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (spi_cs_n_i),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the SCLK path so MOSI lines up with the detected rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q[0] <= spi_mosi_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            err_q       <= 1'b0;
            loaded_q    <= 1'b0;
            alu_valid_q <= 1'b0;
            data_1_q    <= '0;
            data_2_q    <= '0;
            sel_q       <= '0;
        end else begin
            alu_valid_q <= 1'b0;
            if (cs_rise) begin
                // CS rise beats any coincident SCLK edge; that bit is dropped.
                state_q  <= StIdle;
                miso_q   <= 1'b0;
                loaded_q <= 1'b0;
            end else begin
                if (sclk_rise && (state_q inside {StRxCmd, StIssue, StWait, StTx})) begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
                case (state_q)
                    StIdle: begin
                        miso_q <= 1'b0;
                        if (cs_fall) begin
                            bit_cnt_q <= '0;
                            err_q     <= 1'b0;
                            loaded_q  <= 1'b0;
                            state_q   <= StRxCmd;
                        end
                    end
                    StRxCmd: begin
                        if (sclk_rise) begin
                            rx_shift_q <= {rx_shift_q[RX_W-2:0], mosi_s};
                            if (bit_cnt_q == CNT_W'(RX_BITS - 1)) begin
                                state_q <= StIssue;
                            end
                        end
                    end
                    StIssue: begin
                        alu_valid_q <= 1'b1;
                        data_1_q    <= rx_shift_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        data_2_q    <= rx_shift_q[DATA_WIDTH-1:0];
                        sel_q       <= rx_shift_q[RX_W-1 -: SEL_WIDTH];
                        state_q     <= StWait;
                    end
                    StWait: begin
                        if (alu.alu_valid_i) begin
                            tx_shift_q <= alu.alu_data_i;
                            loaded_q   <= 1'b1;
                        end
                        if (sclk_fall && (bit_cnt_q == CNT_W'(TX_START))) begin
                            state_q <= StTx;
                            if (loaded_q) begin
                                {miso_q, tx_shift_q} <= {tx_shift_q, 1'b0};
                            end else if (alu.alu_valid_i) begin
                                {miso_q, tx_shift_q} <= {alu.alu_data_i, 1'b0};
                            end else begin
                                err_q      <= 1'b1;
                                miso_q     <= 1'b0;
                                tx_shift_q <= '0;
                            end
                        end
                    end
                    StTx: begin
                        if (sclk_fall) begin
                            if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
                                state_q <= StDone;
                                miso_q  <= 1'b0;
                            end else begin
                                {miso_q, tx_shift_q} <= {tx_shift_q, 1'b0};
                            end
                        end
                    end
                    StDone: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign spi_miso_o       = miso_q;
    assign busy_o           = (state_q != StIdle);
    assign err_o            = err_q;
    assign alu.alu_valid_o  = alu_valid_q;
    assign alu.alu_data_1_o = data_1_q;
    assign alu.alu_data_2_o = data_2_q;
    assign alu.alu_sel_o    = sel_q;

endmodule

// File: tb/tb_spi_alu_bridge.sv
// Directed bench: SPI master driver, a two-cycle ALU stand-in, and fixed expected results.
module tb_spi_alu_bridge;

    localparam int unsigned DW   = 8;
    localparam int unsigned SW   = 2;
    localparam int unsigned SS   = 2;
    localparam int unsigned HALF = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic miso, busy, err;
    logic alu_en = 1'b1;

    int errors = 0;
    int checks = 0;
    int vcnt   = 0;

    always #5 clk = ~clk;

    spi_alu_bridge_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

    spi_alu_bridge #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk_i(sclk),
        .spi_cs_n_i(cs_n),
        .spi_mosi_i(mosi),
        .spi_miso_o(miso),
        .busy_o    (busy),
        .err_o     (err),
        .alu       (bus)
    );

    function automatic logic [15:0] alu_f(input logic [1:0] sel, input logic [7:0] a,
                                          input logic [7:0] b);
        case (sel)
            2'd0:    return {8'h00, a} + {8'h00, b};
            2'd1:    return {8'h00, a} - {8'h00, b};
            2'd2:    return {8'h00, a} + 16'd1;
            default: return 16'h0000;
        endcase
    endfunction

    // ALU stand-in: result appears two clocks after the request; alu_en=0 makes it mute.
    logic        p1;
    logic [15:0] r1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1              <= 1'b0;
            r1              <= 16'h0;
            bus.alu_valid_i <= 1'b0;
            bus.alu_data_i  <= 16'h0;
        end else begin
            p1              <= bus.alu_valid_o && alu_en;
            r1              <= alu_f(bus.alu_sel_o, bus.alu_data_1_o, bus.alu_data_2_o);
            bus.alu_valid_i <= p1;
            bus.alu_data_i  <= p1 ? r1 : 16'h0;
        end
    end

    always @(posedge clk) begin
        if (bus.alu_valid_o) vcnt <= vcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin();
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_bit(input logic b, output logic s);
        mosi = b;
        wait_clk(HALF);
        s    = miso;
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_end(input int hold);
        wait_clk(HALF);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(hold);
    endtask

    task automatic spi_body(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b,
                            input int nbits, output logic [15:0] res, output int tz_bad);
        logic [23:0] cmd;
        logic        s, bo;
        cmd    = {sel, a, b};
        res    = 16'h0;
        tz_bad = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 24) bo = cmd[23-i];
            else        bo = 1'b1;
            spi_bit(bo, s);
            if (i >= 32 && i < 48) res = {res[14:0], s};
            else if (s)            tz_bad++;
        end
    endtask

    task automatic spi_frame(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b,
                             input int hold, output logic [15:0] res, output int tz_bad);
        spi_begin();
        spi_body(sel, a, b, 48, res, tz_bad);
        spi_end(hold);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_miso"},  {31'h0, miso}, 32'h0);
        check({pfx, "_valid"}, {31'h0, bus.alu_valid_o}, 32'h0);
        check({pfx, "_op1"},   {24'h0, bus.alu_data_1_o}, 32'h0);
        check({pfx, "_op2"},   {24'h0, bus.alu_data_2_o}, 32'h0);
        check({pfx, "_sel"},   {30'h0, bus.alu_sel_o}, 32'h0);
        check({pfx, "_busy"},  {31'h0, busy}, 32'h0);
        check({pfx, "_err"},   {31'h0, err}, 32'h0);
    endtask

    initial begin
        logic [15:0] res;
        int          tz, v0;
        logic        fell;

        wait_clk(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        wait_clk(4);

        v0 = vcnt;
        spi_frame(8'h00, 8'h12, 8'h34, 8, res, tz);
        check("add_res", {16'h0, res}, 32'h0046);
        check("add_valid_cnt", v0 + 1, vcnt);
        check("add_err", {31'h0, err}, 32'h0);
        check("add_op1", {24'h0, bus.alu_data_1_o}, 32'h12);
        check("add_op2", {24'h0, bus.alu_data_2_o}, 32'h34);
        check("add_sel", {30'h0, bus.alu_sel_o}, 32'h0);
        check("add_turn_zero", tz, 0);
        check("add_busy_idle", {31'h0, busy}, 32'h0);

        spi_frame(8'h01, 8'h10, 8'h20, 8, res, tz);
        check("sub_res", {16'h0, res}, 32'hFFF0);
        wait_clk(20);
        check("sub_op1_hold", {24'h0, bus.alu_data_1_o}, 32'h10);

        spi_frame(8'h02, 8'hFF, 8'h00, 4, res, tz);
        check("inc_res", {16'h0, res}, 32'h0100);
        v0 = vcnt;
        spi_frame(8'h03, 8'h55, 8'hAA, 8, res, tz);
        check("sel3_res", {16'h0, res}, 32'h0000);
        check("sel3_sel", {30'h0, bus.alu_sel_o}, 32'h3);
        check("sel3_valid_cnt", v0 + 1, vcnt);

        spi_frame(8'hFD, 8'h30, 8'h05, 8, res, tz);
        check("selhi_res", {16'h0, res}, 32'h002B);
        check("selhi_sel", {30'h0, bus.alu_sel_o}, 32'h1);

        // Abort after ten bits.
        v0 = vcnt;
        spi_begin();
        spi_body(8'h00, 8'hAA, 8'hBB, 10, res, tz);
        @(negedge clk);
        cs_n = 1'b1;
        fell = 1'b0;
        for (int k = 0; k < SS + 2; k++) begin
            wait_clk(1);
            if (!busy) begin
                fell = 1'b1;
                break;
            end
        end
        check("abort_busy_fall", {31'h0, fell}, 32'h1);
        wait_clk(8);
        check("abort_no_valid", vcnt, v0);
        spi_frame(8'h00, 8'h01, 8'h02, 8, res, tz);
        check("abort_next_res", {16'h0, res}, 32'h0003);

        // Mute ALU: result never arrives.
        alu_en = 1'b0;
        v0     = vcnt;
        spi_frame(8'h00, 8'h05, 8'h06, 8, res, tz);
        check("late_res", {16'h0, res}, 32'h0000);
        check("late_err", {31'h0, err}, 32'h1);
        check("late_valid_cnt", v0 + 1, vcnt);
        alu_en = 1'b1;
        spi_begin();
        check("late_err_clear", {31'h0, err}, 32'h0);
        spi_body(8'h02, 8'h41, 8'h00, 48, res, tz);
        spi_end(8);
        check("late_next_res", {16'h0, res}, 32'h0042);

        // Reset in the middle of the result phase.
        spi_begin();
        spi_body(8'h00, 8'h77, 8'h11, 40, res, tz);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        v0 = vcnt;
        spi_body(8'h00, 8'h09, 8'h09, 30, res, tz);
        check("midrst_no_resync_busy", {31'h0, busy}, 32'h0);
        check("midrst_no_valid", vcnt, v0);
        spi_end(8);
        spi_frame(8'h00, 8'h01, 8'h01, 8, res, tz);
        check("midrst_add_res", {16'h0, res}, 32'h0002);
        check("midrst_add_err", {31'h0, err}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
